// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
//   Multi-cycle control unit for the BLOCO datapath (register bank, ALU and
//   flags). It fetches 16-bit instruction words over a req/valid handshake,
//   keeps the PC, decodes each word and sequences the datapath control lines.
//
//   Instruction layout: [15:11] op, [10:9] SC, [8:7] SA, [6:5] SB, [4:0] unused.
//   op 5'b11111 = HALT, op 5'b11110 = CLRF, any other op is an ALU operation.
//
//   Optional feature macro: PASSO_A_PASSO_EN
//     Adds input 'passo' and a wait state. After each ALU op or CLRF the FSM
//     waits until passo=1 before fetching again. HALT is unaffected.
//
// Ports
//   clk, reset_n             clock (rising edge), async active-low reset
//   inicia                   start pulse, honoured only when idle or halted
//   passo                    single-step advance (PASSO_A_PASSO_EN only)
//   inst_req, end_inst       fetch request and fetch address (= PC)
//   inst_valid, instrucao    fetched word and its valid flag
//   Hab_Escrita              register-bank write enable
//   Sel_SA, Sel_SB, Sel_SC   source A, source B and destination selects
//   controleOperacao         ALU operation
//   reset_Flags              flag clear pulse
//   reset_Ban_Registros      register-bank clear pulse
//   parado                   HALT reached
// -----------------------------------------------------------------------------
module unidade_controle #(
  parameter int bits_palavra  = 16,
  parameter int end_registros = 2,
  parameter int bits_pc       = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     inicia,
`ifdef PASSO_A_PASSO_EN
  input  logic                     passo,
`endif
  output logic                     inst_req,
  output logic [bits_pc-1:0]       end_inst,
  input  logic                     inst_valid,
  input  logic [bits_palavra-1:0]  instrucao,
  output logic                     Hab_Escrita,
  output logic [end_registros-1:0] Sel_SA,
  output logic [end_registros-1:0] Sel_SB,
  output logic [end_registros-1:0] Sel_SC,
  output logic [4:0]               controleOperacao,
  output logic                     reset_Flags,
  output logic                     reset_Ban_Registros,
  output logic                     parado
);

  localparam int OP_LSB = 11;
  localparam int SC_LSB = 9;
  localparam int SA_LSB = 7;
  localparam int SB_LSB = 5;

  localparam logic [4:0]         OP_HALT = 5'b11111;
  localparam logic [4:0]         OP_CLRF = 5'b11110;
  localparam logic [bits_pc-1:0] PC_UM   = 1;

  typedef enum logic [2:0] {
    OCIOSO,
    LIMPA,
    BUSCA,
    DECODIFICA,
    EXECUTA,
    LIMPA_FLAGS,   // the single reset_Flags cycle that follows a CLRF decode
    PARADO
`ifdef PASSO_A_PASSO_EN
    , ESPERA
`endif
  } estado_t;

  estado_t                  state_q, state_d;
  logic [bits_pc-1:0]       pc_q, pc_d;
  logic [4:0]               op_q, op_d;
  logic [end_registros-1:0] sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;
  logic                     inst_req_q, inst_req_d;
  logic                     hab_q, hab_d;
  logic                     rst_flags_q, rst_flags_d;
  logic                     rst_ban_q, rst_ban_d;
  logic                     parado_q, parado_d;

  // Low instruction bits carry no meaning for this unit.
  logic unused_campos;
  assign unused_campos = ^instrucao[4:0];

  // Next state. The op/select registers double as the instruction register:
  // they load only when a word is accepted and otherwise hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sc_d    = sc_q;
    case (state_q)
      OCIOSO:      if (inicia) state_d = LIMPA;
      LIMPA:       state_d = BUSCA;
      BUSCA: begin
        if (inst_valid) begin
          state_d = DECODIFICA;
          pc_d    = pc_q + PC_UM;
          op_d    = instrucao[OP_LSB +: 5];
          sc_d    = instrucao[SC_LSB +: end_registros];
          sa_d    = instrucao[SA_LSB +: end_registros];
          sb_d    = instrucao[SB_LSB +: end_registros];
        end
      end
      DECODIFICA: begin
        if (op_q == OP_HALT)      state_d = PARADO;
        else if (op_q == OP_CLRF) state_d = LIMPA_FLAGS;
        else                      state_d = EXECUTA;
      end
`ifdef PASSO_A_PASSO_EN
      EXECUTA, LIMPA_FLAGS: state_d = ESPERA;
      ESPERA:      if (passo) state_d = BUSCA;
`else
      EXECUTA, LIMPA_FLAGS: state_d = BUSCA;
`endif
      PARADO:      if (inicia) state_d = LIMPA;
      default:     state_d = OCIOSO;
    endcase
    // Every (re)start begins fetching from address 0.
    if (state_d == LIMPA) pc_d = '0;
  end

  // Outputs are decoded from the state being entered so that, once
  // registered, they line up with that state.
  always_comb begin
    inst_req_d  = (state_d == BUSCA);
    hab_d       = (state_d == EXECUTA);
    rst_flags_d = (state_d == LIMPA) || (state_d == LIMPA_FLAGS);
    rst_ban_d   = (state_d == LIMPA);
    parado_d    = (state_d == PARADO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= OCIOSO;
      pc_q        <= '0;
      op_q        <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      sc_q        <= '0;
      inst_req_q  <= 1'b0;
      hab_q       <= 1'b0;
      rst_flags_q <= 1'b0;
      rst_ban_q   <= 1'b0;
      parado_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      sc_q        <= sc_d;
      inst_req_q  <= inst_req_d;
      hab_q       <= hab_d;
      rst_flags_q <= rst_flags_d;
      rst_ban_q   <= rst_ban_d;
      parado_q    <= parado_d;
    end
  end

  assign inst_req            = inst_req_q;
  assign end_inst            = pc_q;
  assign Hab_Escrita         = hab_q;
  assign Sel_SA              = sa_q;
  assign Sel_SB              = sb_q;
  assign Sel_SC              = sc_q;
  assign controleOperacao    = op_q;
  assign reset_Flags         = rst_flags_q;
  assign reset_Ban_Registros = rst_ban_q;
  assign parado              = parado_q;

endmodule
